// File: rtl/cosim_stim_gen_pkg.sv
// Shared state encoding and 128-bit LFSR helpers for the cosim stimulus generator.
package cosim_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ZERO,
    ST_ONES,
    ST_WALK1,
    ST_WALK0,
    ST_RAND,
    ST_FIN
  } stim_state_t;

  // Polynomial exponents x^128 + x^126 + x^101 + x^99 + 1 (1-based bit positions).
  localparam int unsigned LFSR_TAP_A = 128;
  localparam int unsigned LFSR_TAP_B = 126;
  localparam int unsigned LFSR_TAP_C = 101;
  localparam int unsigned LFSR_TAP_D = 99;

  function automatic logic [127:0] lfsr128_next(input logic [127:0] s);
    return {s[126:0], s[LFSR_TAP_A-1] ^ s[LFSR_TAP_B-1] ^ s[LFSR_TAP_C-1] ^ s[LFSR_TAP_D-1]};
  endfunction

  function automatic logic [127:0] lfsr128_seed(input logic [127:0] seed);
    return (seed == '0) ? 128'h1 : seed;
  endfunction

endpackage

// File: rtl/cosim_stim_gen_if.sv
// Valid/ready vector channel between the stimulus generator and its consumer.
interface cosim_stim_gen_if #(
  parameter int unsigned WIDTH = 128
);
  logic             vec_valid;
  logic             vec_ready;
  logic [WIDTH-1:0] vec_data;
  logic [15:0]      vec_index;

  modport master (output vec_valid, output vec_data, output vec_index, input vec_ready);
  modport slave  (input vec_valid, input vec_data, input vec_index, output vec_ready);
endinterface

// File: rtl/cosim_stim_gen_lfsr128.sv
// 128-bit Fibonacci LFSR: reseeds on reset or load, advances only when stepped.
module lfsr128 (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [127:0] seed,
  input  logic         step,
  output logic [127:0] state
);
  import cosim_stim_pkg::*;

  logic [127:0] state_q;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      state_q <= lfsr128_seed(seed);
    end else if (step) begin
      state_q <= lfsr128_next(state_q);
    end
  end

  assign state = state_q;
endmodule

// File: rtl/cosim_stim_gen.sv
// Deterministic stimulus sequencer: zeros, ones, walking-1, walking-0, then LFSR vectors.
module cosim_stim_gen #(
  parameter int unsigned  WIDTH    = 128,
  parameter int unsigned  NUM_RAND = 256,
  parameter logic [127:0] SEED     = 128'h1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  cosim_stim_gen_if.master vec
);
  import cosim_stim_pkg::*;

  localparam logic [7:0]       POS_LAST = 8'(WIDTH - 1);
  localparam logic [15:0]      CNT_LAST = 16'(NUM_RAND - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  stim_state_t      state_q;
  logic [7:0]       pos_q;
  logic [15:0]      cnt_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] data_q;
  logic [15:0]      index_q;

  logic [127:0] lfsr_state;
  logic [127:0] lfsr_stepped;
  logic         xfer;
  logic         lfsr_load;
  logic         lfsr_step;
  logic [7:0]   pos_inc;
  logic         unused_lfsr;

  assign xfer         = valid_q && vec.vec_ready;
  assign lfsr_load    = (state_q == ST_IDLE) && start;
  assign lfsr_step    = (state_q == ST_RAND) && xfer;
  assign lfsr_stepped = lfsr128_next(lfsr_state);
  assign pos_inc      = pos_q + 8'd1;
  assign unused_lfsr  = ^{lfsr_state, lfsr_stepped};

  lfsr128 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .seed  (SEED),
    .step  (lfsr_step),
    .state (lfsr_state)
  );

  // The next vector is loaded on the transfer edge, so the RAND entry uses the
  // unstepped LFSR and later RAND vectors use the value the LFSR steps to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pos_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (xfer) index_q <= index_q + 16'd1;
      unique case (state_q)
        ST_IDLE: if (start) begin
          state_q <= ST_ZERO;
          valid_q <= 1'b1;
          busy_q  <= 1'b1;
          data_q  <= '0;
          index_q <= '0;
          pos_q   <= '0;
          cnt_q   <= '0;
        end
        ST_ZERO: if (xfer) begin
          state_q <= ST_ONES;
          data_q  <= '1;
        end
        ST_ONES: if (xfer) begin
          state_q <= ST_WALK1;
          pos_q   <= '0;
          data_q  <= ONE;
        end
        ST_WALK1: if (xfer) begin
          if (pos_q == POS_LAST) begin
            state_q <= ST_WALK0;
            pos_q   <= '0;
            data_q  <= ~ONE;
          end else begin
            pos_q  <= pos_inc;
            data_q <= ONE << pos_inc;
          end
        end
        ST_WALK0: if (xfer) begin
          if (pos_q == POS_LAST) begin
            pos_q <= '0;
            cnt_q <= '0;
            if (NUM_RAND == 0) begin
              state_q <= ST_FIN;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RAND;
              data_q  <= lfsr_state[WIDTH-1:0];
            end
          end else begin
            pos_q  <= pos_inc;
            data_q <= ~(ONE << pos_inc);
          end
        end
        ST_RAND: if (xfer) begin
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_FIN;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q  <= cnt_q + 16'd1;
            data_q <= lfsr_stepped[WIDTH-1:0];
          end
        end
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign vec.vec_valid = valid_q;
  assign vec.vec_data  = data_q;
  assign vec.vec_index = index_q;
  assign busy          = busy_q;
  assign done          = done_q;
endmodule

// File: tb/tb_cosim_stim_gen.sv
// Bench for cosim_stim_gen: three configurations checked every cycle against a sequence model.
module tb_cosim_stim_gen;
  import cosim_stim_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, start, busy, done;

  cosim_stim_gen_if #(.WIDTH(128)) if0 ();
  cosim_stim_gen_if #(.WIDTH(9))   if1 ();
  cosim_stim_gen_if #(.WIDTH(128)) if2 ();

  cosim_stim_gen #(.WIDTH(128), .NUM_RAND(4), .SEED(128'h1)) u0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .busy(busy[0]), .done(done[0]), .vec(if0));
  cosim_stim_gen #(.WIDTH(9), .NUM_RAND(0), .SEED(128'h1)) u1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .busy(busy[1]), .done(done[1]), .vec(if1));
  cosim_stim_gen #(.WIDTH(128), .NUM_RAND(8), .SEED(128'h0)) u2 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .busy(busy[2]), .done(done[2]), .vec(if2));

  // u2 has a zero seed, so its stream must equal the seed-1 stream.
  int unsigned CFG_W  [3] = '{128, 9, 128};
  int unsigned CFG_NR [3] = '{4, 0, 8};

  int           phase [3];  // 0 idle, 1 emitting, 2 done cycle
  int           idx   [3];
  int           xfers [3];
  int           dones [3];
  bit           prv_stall [3];
  logic [127:0] prv_data  [3];
  logic [15:0]  prv_index [3];
  logic [127:0] cap0 [0:261];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] expect_vec(input int i, input int w, input int nr);
    logic [127:0] mask;
    logic [127:0] s;
    mask = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
    if (i == 0) return '0;
    if (i == 1) return mask;
    if (i < 2 + w) return 128'd1 << (i - 2);
    if (i < 2 + 2 * w) return ~(128'd1 << (i - 2 - w)) & mask;
    s = 128'h1;
    for (int n = 0; n < i - 2 - 2 * w; n++) s = lfsr128_next(s);
    return s & mask;
  endfunction

  task automatic model_cycle(input int k, input logic r, input logic s, input logic v,
                             input logic rdy, input logic b, input logic d,
                             input logic [127:0] data, input logic [15:0] index);
    int w;
    int total;
    w     = int'(CFG_W[k]);
    total = 2 + 2 * w + int'(CFG_NR[k]);
    chk($sformatf("u%0d valid", k), v, (phase[k] == 1));
    chk($sformatf("u%0d busy", k), b, (phase[k] == 1));
    chk($sformatf("u%0d done", k), d, (phase[k] == 2));
    if (v) begin
      chk($sformatf("u%0d data@%0d", k, idx[k]), data, expect_vec(idx[k], w, int'(CFG_NR[k])));
      chk($sformatf("u%0d index", k), index, 16'(idx[k]));
      if (prv_stall[k]) begin
        chk($sformatf("u%0d hold data", k), data, prv_data[k]);
        chk($sformatf("u%0d hold index", k), index, prv_index[k]);
      end
      if (k == 2 && idx[k] >= 2 + 2 * w) chk("u2 rand nonzero", (data != '0), 1'b1);
      if (k == 0 && idx[k] < 262) cap0[idx[k]] = data;
    end
    if (v && rdy) xfers[k]++;
    if (d) dones[k]++;
    prv_stall[k] = v && !rdy;
    prv_data[k]  = data;
    prv_index[k] = index;
    if (r) begin
      phase[k]     = 0;
      prv_stall[k] = 1'b0;
    end else begin
      case (phase[k])
        0: if (s) begin phase[k] = 1; idx[k] = 0; end
        1: if (rdy) begin
          idx[k]++;
          if (idx[k] == total) phase[k] = 2;
        end
        default: phase[k] = 0;
      endcase
    end
  endtask

  always @(negedge clk) begin
    model_cycle(0, rst[0], start[0], if0.vec_valid, if0.vec_ready, busy[0], done[0],
                if0.vec_data, if0.vec_index);
    model_cycle(1, rst[1], start[1], if1.vec_valid, if1.vec_ready, busy[1], done[1],
                128'(if1.vec_data), if1.vec_index);
    model_cycle(2, rst[2], start[2], if2.vec_valid, if2.vec_ready, busy[2], done[2],
                if2.vec_data, if2.vec_index);
  end

  task automatic clear_counts();
    for (int k = 0; k < 3; k++) begin
      xfers[k] = 0;
      dones[k] = 0;
    end
  endtask

  task automatic pulse_start(input logic [2:0] which);
    @(posedge clk); #1;
    start = which;
    @(posedge clk); #1;
    start = '0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      phase[k] = 0; idx[k] = 0; prv_stall[k] = 1'b0;
    end
    clear_counts();
    rst = '1;
    start = '0;
    if0.vec_ready = 1'b1;
    if1.vec_ready = 1'b1;
    if2.vec_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid", if0.vec_valid, 1'b0);
    chk("reset data", if0.vec_data, '0);
    chk("reset index", if0.vec_index, '0);
    chk("reset busy", busy[0], 1'b0);
    chk("reset done", done[0], 1'b0);
    rst = '0;

    // Run 1: all three configurations, consumer always ready.
    pulse_start(3'b111);
    chk("latency valid", if0.vec_valid, 1'b1);
    chk("latency data", if0.vec_data, '0);
    for (int c = 0; c < 400 && !(dones[0] > 0 && dones[1] > 0 && dones[2] > 0); c++)
      @(posedge clk);
    repeat (3) @(posedge clk);
    chk("run1 u0 vectors", xfers[0], 262);
    chk("run1 u1 vectors", xfers[1], 20);
    chk("run1 u2 vectors", xfers[2], 266);
    chk("run1 u0 dones", dones[0], 1);
    chk("run1 u1 dones", dones[1], 1);
    chk("run1 u2 dones", dones[2], 1);
    chk("pin idx0", cap0[0], 128'h0);
    chk("pin idx1", cap0[1], {128{1'b1}});
    chk("pin idx2", cap0[2], 128'h1);
    chk("pin idx129", cap0[129], 128'h8000_0000_0000_0000_0000_0000_0000_0000);
    chk("pin idx130", cap0[130], 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);
    chk("pin idx258", cap0[258], 128'h1);
    chk("pin idx259", cap0[259], 128'h2);
    chk("pin idx261", cap0[261], 128'h8);

    // Run 2: random stalls on u0, start pulsed at index 10 and in the done cycle.
    clear_counts();
    pulse_start(3'b001);
    begin
      bit at10 = 1'b0;
      bit fin_seen = 1'b0;
      for (int c = 0; c < 3000 && !fin_seen; c++) begin
        @(posedge clk); #1;
        start = '0;
        if0.vec_ready = 1'($urandom_range(0, 1));
        if (!at10 && if0.vec_valid && if0.vec_index == 16'd10) begin
          start = 3'b001;
          at10 = 1'b1;
        end
        if (done[0]) begin
          start = 3'b001;
          fin_seen = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    start = '0;
    if0.vec_ready = 1'b1;
    repeat (6) @(posedge clk);
    chk("run2 vectors", xfers[0], 262);
    chk("run2 dones", dones[0], 1);

    // Run 3: reset at index 140, then a fresh sequence.
    clear_counts();
    pulse_start(3'b001);
    for (int c = 0; c < 400 && !(if0.vec_valid && if0.vec_index == 16'd140); c++) begin
      @(posedge clk); #1;
    end
    rst = 3'b001;
    @(posedge clk); #1;
    rst = '0;
    chk("abort valid", if0.vec_valid, 1'b0);
    chk("abort dones", dones[0], 0);
    clear_counts();
    pulse_start(3'b001);
    for (int c = 0; c < 400 && dones[0] == 0; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("run3 vectors", xfers[0], 262);
    chk("run3 dones", dones[0], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
